mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding and default bus widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } arb_state_e;

    localparam int DEFAULT_ADDR_WIDTH      = 32;
    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between instruction fetch and load/store.
// Data wins by default, but a pending fetch is served after MAX_DATA_STREAK data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inst_request_core2mem,
    input  logic [INST_ADDR_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0]      inst_rdata,
    output logic                       inst_valid,
    input  logic                       data_request,
    input  logic                       data_we,
    input  logic [INST_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_wdata,
    output logic [DATA_WIDTH-1:0]      data_rdata,
    output logic                       data_valid,
    output logic                       stall_PC,
    output logic                       stall_MEM,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ready,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e                 state_q, state_d;
    logic [STREAK_W-1:0]        streak_q, streak_d;
    logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       we_q, we_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0]      data_rdata_q, data_rdata_d;
    logic                       inst_valid_q, inst_valid_d;
    logic                       data_valid_q, data_valid_d;
    logic                       grant_data;
    logic                       grant_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;
        grant_data   = data_request && (!inst_request_core2mem || (streak_q < STREAK_MAX));
        grant_inst   = !grant_data && inst_request_core2mem;

        case (state_q)
            IDLE: begin
                // The streak only matters while a fetch is actually waiting.
                if (!inst_request_core2mem) begin
                    streak_d = '0;
                end
                if (grant_data) begin
                    state_d = DATA_BUSY;
                    addr_d  = data_addr;
                    we_d    = data_we;
                    wdata_d = data_wdata;
                    if (inst_request_core2mem && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_inst) begin
                    state_d  = INST_BUSY;
                    addr_d   = PC;
                    we_d     = 1'b0;
                    wdata_d  = data_wdata;
                    streak_d = '0;
                end
            end
            INST_BUSY: begin
                if (mem_ready) begin
                    inst_rdata_d = mem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            DATA_BUSY: begin
                if (mem_ready) begin
                    // Stores complete with a pulse but leave the load data untouched.
                    if (!we_q) begin
                        data_rdata_d = mem_rdata;
                    end
                    data_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req    = (state_q != IDLE);
        mem_we     = we_q && (state_q != IDLE);
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        inst_rdata = inst_rdata_q;
        data_rdata = data_rdata_q;
        inst_valid = inst_valid_q;
        data_valid = data_valid_q;
        stall_PC   = inst_request_core2mem && !inst_valid_q;
        stall_MEM  = data_request && !data_valid_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: latency, priority, streak limit,
// wait states, mid-transaction reset and request withdrawal.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_request_core2mem;
    logic [31:0] PC;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        data_request;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        stall_PC;
    logic        stall_MEM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .INST_ADDR_WIDTH(32),
        .DATA_WIDTH     (32),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .inst_request_core2mem(inst_request_core2mem),
        .PC                   (PC),
        .inst_rdata           (inst_rdata),
        .inst_valid           (inst_valid),
        .data_request         (data_request),
        .data_we              (data_we),
        .data_addr            (data_addr),
        .data_wdata           (data_wdata),
        .data_rdata           (data_rdata),
        .data_valid           (data_valid),
        .stall_PC             (stall_PC),
        .stall_MEM            (stall_MEM),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_ready            (mem_ready),
        .mem_rdata            (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int pulses;

    initial begin
        rst_n                 = 1'b0;
        inst_request_core2mem = 1'b0;
        PC                    = '0;
        data_request          = 1'b0;
        data_we               = 1'b0;
        data_addr             = '0;
        data_wdata            = '0;
        mem_ready             = 1'b0;
        mem_rdata             = '0;

        // Reset values, observed before any clock edge.
        #2;
        check("rst_mem_req",    32'(mem_req),    32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_inst_rdata", inst_rdata,      32'd0);
        check("rst_data_rdata", data_rdata,      32'd0);
        @(posedge clk);
        next_cycle();
        rst_n = 1'b1;

        // Minimum-latency fetch from PC=0.
        inst_request_core2mem = 1'b1;
        PC        = 32'h0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        settle();
        check("t1_c0_stall_pc", 32'(stall_PC), 32'd1);
        check("t1_c0_mem_req",  32'(mem_req),  32'd0);
        next_cycle(); settle();
        check("t1_c1_mem_req",  32'(mem_req),  32'd1);
        check("t1_c1_mem_addr", mem_addr,      32'h0);
        check("t1_c1_mem_we",   32'(mem_we),   32'd0);
        check("t1_c1_stall_pc", 32'(stall_PC), 32'd1);
        next_cycle(); settle();
        check("t1_c2_inst_valid", 32'(inst_valid), 32'd1);
        check("t1_c2_inst_rdata", inst_rdata,      32'h1111_1111);
        check("t1_c2_stall_pc",   32'(stall_PC),   32'd0);
        check("t1_c2_mem_req",    32'(mem_req),    32'd0);
        inst_request_core2mem = 1'b0;
        $display("txn fetch   addr=0x%08h rdata=0x%08h", 32'h0, inst_rdata);
        next_cycle(); settle();
        check("t1_c3_inst_valid", 32'(inst_valid), 32'd0);
        check("t1_c3_inst_hold",  inst_rdata,      32'h1111_1111);
        check("t1_c3_mem_req",    32'(mem_req),    32'd0);

        // Simultaneous requests: data first, inst after one IDLE cycle.
        inst_request_core2mem = 1'b1;
        PC           = 32'h10;
        data_request = 1'b1;
        data_we      = 1'b0;
        data_addr    = 32'h100;
        mem_rdata    = 32'h2222_2222;
        next_cycle(); settle();
        check("t2_c1_mem_addr",  mem_addr,       32'h100);
        check("t2_c1_stall_mem", 32'(stall_MEM), 32'd1);
        check("t2_c1_stall_pc",  32'(stall_PC),  32'd1);
        next_cycle(); settle();
        check("t2_c2_data_valid", 32'(data_valid), 32'd1);
        check("t2_c2_data_rdata", data_rdata,      32'h2222_2222);
        check("t2_c2_stall_mem",  32'(stall_MEM),  32'd0);
        check("t2_c2_mem_req",    32'(mem_req),    32'd0);
        data_request = 1'b0;
        mem_rdata    = 32'h3333_3333;
        $display("txn load    addr=0x%08h rdata=0x%08h", 32'h100, data_rdata);
        next_cycle(); settle();
        check("t2_c3_mem_req",  32'(mem_req), 32'd1);
        check("t2_c3_mem_addr", mem_addr,     32'h10);
        next_cycle(); settle();
        check("t2_c4_inst_valid", 32'(inst_valid), 32'd1);
        check("t2_c4_inst_rdata", inst_rdata,      32'h3333_3333);
        inst_request_core2mem = 1'b0;
        $display("txn fetch   addr=0x%08h rdata=0x%08h", 32'h10, inst_rdata);
        next_cycle();

        // Streak limit: four data grants, then the fetch, then data again.
        inst_request_core2mem = 1'b1;
        PC           = 32'h40;
        data_request = 1'b1;
        data_addr    = 32'h200;
        mem_rdata    = 32'h4444_4444;
        for (int c = 0; c < 12; c++) begin
            settle();
            check($sformatf("t3_c%0d_mem_req", c), 32'(mem_req), 32'((c % 2) == 1));
            if ((c % 2) == 1) begin
                check($sformatf("t3_c%0d_mem_addr", c), mem_addr, (c == 9) ? 32'h40 : 32'h200);
                $display("txn streak  cycle=%0d addr=0x%08h", c, mem_addr);
            end
            if (c == 11) begin
                inst_request_core2mem = 1'b0;
                data_request          = 1'b0;
            end
            next_cycle();
        end
        settle();
        check("t3_c12_data_valid", 32'(data_valid), 32'd1);
        check("t3_c12_data_rdata", data_rdata,      32'h4444_4444);
        check("t3_c12_mem_req",    32'(mem_req),    32'd0);
        next_cycle();

        // Store with three wait states; capture registers must not track inputs.
        data_request = 1'b1;
        data_we      = 1'b1;
        data_addr    = 32'h20;
        data_wdata   = 32'hDEAD_BEEF;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h5555_5555;
        next_cycle();
        data_addr  = 32'hFFFF_0000;
        data_wdata = 32'h0BAD_F00D;
        data_we    = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) mem_ready = 1'b1;
            settle();
            check($sformatf("t4_c%0d_mem_req", c),   32'(mem_req),    32'd1);
            check($sformatf("t4_c%0d_mem_we", c),    32'(mem_we),     32'd1);
            check($sformatf("t4_c%0d_mem_addr", c),  mem_addr,        32'h20);
            check($sformatf("t4_c%0d_mem_wdata", c), mem_wdata,       32'hDEAD_BEEF);
            check($sformatf("t4_c%0d_dvalid", c),    32'(data_valid), 32'd0);
            next_cycle();
        end
        settle();
        check("t4_c5_data_valid", 32'(data_valid), 32'd1);
        check("t4_c5_data_rdata", data_rdata,      32'h4444_4444);
        check("t4_c5_stall_mem",  32'(stall_MEM),  32'd0);
        data_request = 1'b0;
        $display("txn store   addr=0x%08h wdata=0x%08h", 32'h20, 32'hDEAD_BEEF);
        next_cycle(); settle();
        check("t4_c6_data_valid", 32'(data_valid), 32'd0);
        check("t4_c6_mem_req",    32'(mem_req),    32'd0);

        // Reset during DATA_BUSY abandons the load.
        data_request = 1'b1;
        data_addr    = 32'h300;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h9999_9999;
        next_cycle(); settle();
        check("t5_busy_mem_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_mem_req",    32'(mem_req),  32'd0);
        check("t5_rst_mem_addr",   mem_addr,      32'd0);
        check("t5_rst_data_rdata", data_rdata,    32'd0);
        data_request = 1'b0;
        mem_ready    = 1'b1;
        next_cycle();
        check("t5_rst_data_valid", 32'(data_valid), 32'd0);
        rst_n        = 1'b1;
        data_request = 1'b1;
        data_addr    = 32'h304;
        mem_rdata    = 32'h6666_6666;
        next_cycle(); settle();
        check("t5_post_mem_req",  32'(mem_req), 32'd1);
        check("t5_post_mem_addr", mem_addr,     32'h304);
        next_cycle(); settle();
        check("t5_post_data_valid", 32'(data_valid), 32'd1);
        check("t5_post_data_rdata", data_rdata,      32'h6666_6666);
        data_request = 1'b0;
        $display("txn load    addr=0x%08h rdata=0x%08h", 32'h304, data_rdata);
        next_cycle();

        // Fetch withdrawn during INST_BUSY still completes exactly once.
        inst_request_core2mem = 1'b1;
        PC        = 32'h80;
        mem_ready = 1'b0;
        mem_rdata = 32'h7777_7777;
        next_cycle();
        inst_request_core2mem = 1'b0;
        settle();
        check("t6_c1_mem_req",  32'(mem_req),  32'd1);
        check("t6_c1_mem_addr", mem_addr,      32'h80);
        check("t6_c1_stall_pc", 32'(stall_PC), 32'd0);
        next_cycle();
        mem_ready = 1'b1;
        pulses = 0;
        for (int c = 3; c <= 6; c++) begin
            next_cycle(); settle();
            if (inst_valid) pulses++;
            if (c == 3) check("t6_c3_inst_rdata", inst_rdata, 32'h7777_7777);
            if (c >= 4) check($sformatf("t6_c%0d_mem_req", c), 32'(mem_req), 32'd0);
        end
        check("t6_valid_pulses", 32'(pulses), 32'd1);
        $display("txn fetch   addr=0x%08h rdata=0x%08h (withdrawn)", 32'h80, inst_rdata);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
